// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state codes, engine modes and the sign-extension helper for alu_seq.
package alu_pkg;

    localparam logic [3:0] OP_ADDI = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ANDI = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_NOTI = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1010;
    localparam logic [3:0] OP_LEA  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1110;
    localparam logic [3:0] OP_MUL  = 4'b0011;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] IT_SHL = 2'd0;
    localparam logic [1:0] IT_SHR = 2'd1;
    localparam logic [1:0] IT_MUL = 2'd2;

    // Callers truncate the 64-bit result to their own width.
    function automatic logic [63:0] sext(input logic [63:0] x, input int msb);
        logic [63:0] hi;
        hi = ~64'd0 << msb;
        return x[msb] ? (x | hi) : (x & ~hi);
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: one-bit-per-cycle shift / shift-add multiply engine with load, step and done.
// The multiplier accumulator and multiplicand path exist only when ALU_MUL_EN is defined.
module alu_seq_iter
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CW     = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] a_i,
`ifdef ALU_MUL_EN
    input  logic [DATA_W-1:0] b_i,
`endif
    input  logic [CW-1:0]     cnt_i,
    output logic [DATA_W-1:0] next_o,
    output logic              done_o
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        mode_q;

    assign a_d    = mode_q == IT_SHR ? a_q >> 1 : a_q << 1;
    // done_o flags the final step, so next_o is the finished value on that edge.
    assign done_o = cnt_q == CW'(1);

`ifdef ALU_MUL_EN
    logic [DATA_W-1:0] b_q, acc_q, acc_d;

    assign acc_d  = acc_q + (b_q[0] ? a_q : '0);
    assign next_o = mode_q == IT_MUL ? acc_d : a_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q   <= '0;
            acc_q <= '0;
        end else if (load_i) begin
            b_q   <= b_i;
            acc_q <= '0;
        end else if (step_i) begin
            b_q   <= b_q >> 1;
            acc_q <= acc_d;
        end
    end
`else
    assign next_o = a_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            cnt_q  <= '0;
            mode_q <= IT_SHL;
        end else if (load_i) begin
            a_q    <= a_i;
            cnt_q  <= cnt_i;
            mode_q <= mode_i;
        end else if (step_i && cnt_q != '0) begin
            a_q    <= a_d;
            cnt_q  <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshake, registered result and NZP flags.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 0011.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMM_W  = 6,
    parameter int PC_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [IMM_W-1:0]  ins_immediate,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] reg_sr1_out,
    input  logic [DATA_W-1:0] reg_sr2_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              negative,
    output logic              zero,
    output logic              positive,
    output logic              busy
);

    localparam int SW = $clog2(DATA_W);
    localparam int CW = SW + 1;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d, simm, single_res, iter_next;
    logic [2:0]        flags_q;
    logic [PC_W-1:0]   lea_lo;
    logic [CW-1:0]     iter_cnt;
    logic [1:0]        iter_mode;
    logic              is_iter, load, step, upd, iter_done;

    assign simm      = DATA_W'(sext(64'(ins_immediate[IMM_W-2:0]), IMM_W-2));
    assign lea_lo    = pc + PC_W'(sext(64'(ins_immediate), IMM_W-1));
    assign iter_mode = op == OP_SHR ? IT_SHR : op == OP_SHL ? IT_SHL : IT_MUL;
    assign iter_cnt  = op == OP_MUL ? CW'(DATA_W) : CW'(reg_sr2_out[SW-1:0]);
`ifdef ALU_MUL_EN
    assign is_iter   = op == OP_SHL || op == OP_SHR || op == OP_MUL;
`else
    assign is_iter   = op == OP_SHL || op == OP_SHR;
`endif

    always_comb begin
        case (op)
            OP_ADDI: single_res = reg_sr1_out + simm;
            OP_ADD:  single_res = reg_sr1_out + reg_sr2_out;
            OP_ANDI: single_res = reg_sr1_out & simm;
            OP_AND:  single_res = reg_sr1_out & reg_sr2_out;
            OP_NOTI: single_res = ~simm;
            OP_NOT:  single_res = ~reg_sr1_out;
            OP_LEA:  single_res = DATA_W'({{DATA_W{ins_immediate[IMM_W-1]}}, lea_lo});
            OP_SHL,
            OP_SHR:  single_res = reg_sr1_out;
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        upd      = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                if (is_iter && iter_cnt != '0) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end else begin
                    result_d = single_res;
                    upd      = 1'b1;
                    state_d  = DONE;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (iter_done) begin
                    result_d = iter_next;
                    upd      = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (upd) flags_q <= {result_d[DATA_W-1], result_d == '0, !result_d[DATA_W-1] && result_d != '0};
        end
    end

    alu_seq_iter #(.DATA_W(DATA_W), .CW(CW)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .step_i (step),
        .mode_i (iter_mode),
        .a_i    (reg_sr1_out),
`ifdef ALU_MUL_EN
        .b_i    (reg_sr2_out),
`endif
        .cnt_i  (iter_cnt),
        .next_o (iter_next),
        .done_o (iter_done)
    );

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q == BUSY;
    assign result    = result_q;
    assign {negative, zero, positive} = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, hand-written handshake/reset sequences and random ops against a reference model.
// Expectations for opcode 0011 follow ALU_MUL_EN.
module tb_alu_seq;

    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] op = '0;
    logic [5:0] imm = '0, pc = '0;
    logic [7:0] sr1 = '0, sr2 = '0;
    logic       in_ready, out_valid, negative, zero, positive, busy;
    logic [7:0] result;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op            (op),
        .ins_immediate (imm),
        .pc            (pc),
        .reg_sr1_out   (sr1),
        .reg_sr2_out   (sr2),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .negative      (negative),
        .zero          (zero),
        .positive      (positive),
        .busy          (busy)
    );

    typedef struct {
        logic [3:0] op;
        logic [5:0] imm;
        logic [5:0] pc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        int         lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [2:0] nzp(input logic [7:0] r);
        return {r[7], r == 8'd0, !r[7] && r != 8'd0};
    endfunction

    // Reference computed straight from the opcode definitions with integer arithmetic.
    task automatic model(input logic [3:0] o, input logic [5:0] i_imm, input logic [5:0] i_pc,
                         input logic [7:0] a, input logic [7:0] b, output logic [7:0] r, output int lat);
        int s5, s6, k;
        s5  = i_imm[4] ? int'(i_imm[4:0]) - 32 : int'(i_imm[4:0]);
        s6  = i_imm[5] ? int'(i_imm) - 64 : int'(i_imm);
        k   = int'(b) % 8;
        lat = 1;
        r   = 8'h00;
        case (o)
            4'b0000: r = 8'(int'(a) + s5);
            4'b0010: r = 8'(int'(a) + int'(b));
            4'b0100: r = a & 8'(s5);
            4'b0110: r = a & b;
            4'b1000: r = ~8'(s5);
            4'b1010: r = ~a;
            4'b1101: r = (i_imm[5] ? 8'hC0 : 8'h00) | 8'((int'(i_pc) + s6) & 63);
            4'b1100: begin r = 8'((int'(a) * (1 << k)) % 256); lat = 1 + k; end
            4'b1110: begin r = 8'(int'(a) / (1 << k)); lat = 1 + k; end
`ifdef ALU_MUL_EN
            4'b0011: begin r = 8'((int'(a) * int'(b)) % 256); lat = 9; end
`endif
            default: r = 8'h00;
        endcase
    endtask

    task automatic scramble();
        op  = 4'($urandom);
        imm = 6'($urandom);
        pc  = 6'($urandom);
        sr1 = 8'($urandom);
        sr2 = 8'($urandom);
    endtask

    task automatic run(input logic [3:0] o, input logic [5:0] i_imm, input logic [5:0] i_pc,
                       input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic [2:0] f, output int lat, output bit hs_ok);
        hs_ok = in_ready === 1'b1 && out_valid === 1'b0;
        op = o; imm = i_imm; pc = i_pc; sr1 = a; sr2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
        lat = 1;
        while (out_valid !== 1'b1 && lat < 64) begin
            hs_ok = hs_ok && in_ready === 1'b0 && busy === 1'b1;
            scramble();
            @(posedge clk); #1;
            lat++;
        end
        hs_ok = hs_ok && in_ready === 1'b0 && busy === 1'b0;
        r = result;
        f = {negative, zero, positive};
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [3:0] o, input logic [5:0] i_imm,
                            input logic [5:0] i_pc, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp_r, input int exp_lat);
        logic [7:0] r;
        logic [2:0] f;
        int         lat;
        bit         hs_ok;
        run(o, i_imm, i_pc, a, b, r, f, lat, hs_ok);
        chk({name, " result"}, 32'(r), 32'(exp_r));
        chk({name, " nzp"}, 32'(f), 32'(nzp(exp_r)));
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " handshake"}, 32'(hs_ok), 32'd1);
        consume();
    endtask

    initial begin
        logic [7:0] mr;
        int         ml, n, last;
        vecs = '{
            '{4'b0000, 6'h1E, 6'h00, 8'h05, 8'h00, 8'h03, 1},
            '{4'b1101, 6'h03, 6'h3E, 8'h00, 8'h00, 8'h01, 1},
            '{4'b1101, 6'h3F, 6'h00, 8'h00, 8'h00, 8'hFF, 1},
            '{4'b1100, 6'h00, 6'h00, 8'h81, 8'h03, 8'h08, 4},
            '{4'b1110, 6'h00, 6'h00, 8'hA5, 8'h00, 8'hA5, 1},
            '{4'b1110, 6'h00, 6'h00, 8'h80, 8'h07, 8'h01, 8},
            '{4'b0010, 6'h00, 6'h00, 8'hFF, 8'h01, 8'h00, 1},
            '{4'b0100, 6'h10, 6'h00, 8'hFF, 8'h00, 8'hF0, 1},
            '{4'b1000, 6'h00, 6'h00, 8'h00, 8'h00, 8'hFF, 1},
            '{4'b1010, 6'h00, 6'h00, 8'hFF, 8'h00, 8'h00, 1},
            '{4'b0110, 6'h00, 6'h00, 8'hF0, 8'h3C, 8'h30, 1},
            '{4'b0001, 6'h15, 6'h07, 8'h12, 8'h34, 8'h00, 1},
`ifdef ALU_MUL_EN
            '{4'b0011, 6'h00, 6'h00, 8'h0F, 8'h11, 8'hFF, 9}
`else
            '{4'b0011, 6'h00, 6'h00, 8'h0F, 8'h11, 8'h00, 1}
`endif
        };

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset nzp", 32'({negative, zero, positive}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++)
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].imm, vecs[i].pc,
                     vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat);

        begin
            logic [7:0] r;
            logic [2:0] f;
            int         lat;
            bit         hs_ok;
            run(4'b0000, 6'h1E, 6'h00, 8'h05, 8'h00, r, f, lat, hs_ok);
            chk("hold first", 32'({r, f}), 32'({8'h03, 3'b001}));
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                chk($sformatf("hold%0d", k), 32'({out_valid, result, negative, zero, positive}),
                    32'({1'b1, 8'h03, 3'b001}));
            end
            consume();
        end

        op = 4'b0010; sr1 = 8'h01; sr2 = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        last = 0;
        for (int c = 0; c < 12; c++) begin
            if (in_ready === 1'b1) begin
                if (n > 0) chk("accept gap", 32'(c - last), 32'd2);
                last = c;
                n++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("accept count", 32'(n), 32'd6);
        chk("stream result", 32'(result), 32'h03);

        op = 4'b0011; sr1 = 8'h0F; sr2 = 8'h11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort state", 32'({in_ready, out_valid, busy}), 32'b100);
        chk("abort result", 32'(result), 32'd0);
        chk("abort nzp", 32'({negative, zero, positive}), 32'd0);
        check_op("after abort", 4'b0110, 6'h00, 6'h00, 8'hF0, 8'h3C, 8'h30, 1);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] o;
            logic [5:0] ri, rp;
            logic [7:0] ra, rb;
            o = 4'($urandom); ri = 6'($urandom); rp = 6'($urandom);
            ra = 8'($urandom); rb = 8'($urandom);
            model(o, ri, rp, ra, rb, mr, ml);
            check_op($sformatf("rand%0d op%b", i, o), o, ri, rp, ra, rb, mr, ml);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
